// File: rtl/debug_controller.sv
// Debug command sequencer between the UART command decoder and the MCU debug port.
// One command is accepted per in_valid strobe while idle; busy covers the whole operation
// and d_rd/error hold the result until the next accepted command.
module debug_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic        in_valid,
  output logic        busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic        mcu_pause,
  input  logic        mcu_paused,
  output logic        mcu_reset,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        reg_rd,
  output logic        reg_we,
  output logic [31:0] dbg_addr,
  output logic [31:0] dbg_din,
  input  logic [31:0] mcu_dout,
  input  logic        mcu_ack
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Last waiting cycle: the counter value that would increment to TIMEOUT_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] CmdNop    = 4'h0;
  localparam logic [3:0] CmdPause  = 4'h1;
  localparam logic [3:0] CmdResume = 4'h2;
  localparam logic [3:0] CmdStatus = 4'h3;
  localparam logic [3:0] CmdReset  = 4'h4;
  localparam logic [3:0] CmdMemRd  = 4'h5;
  localparam logic [3:0] CmdMemWr  = 4'h6;
  localparam logic [3:0] CmdRegRd  = 4'h7;
  localparam logic [3:0] CmdRegWr  = 4'h8;

  localparam logic [31:0] ErrWord = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StPauseWait,
    StResumeWait,
    StAccess,
    StDone
  } state_e;

  state_e          state;
  logic [3:0]      cmd_q;
  logic [31:0]     addr_q;
  logic [31:0]     din_q;
  logic [CntW-1:0] cnt;

  // Command FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      cmd_q     <= 4'h0;
      addr_q    <= 32'h0;
      din_q     <= 32'h0;
      cnt       <= '0;
      busy      <= 1'b0;
      d_rd      <= 32'h0;
      error     <= 1'b0;
      mcu_pause <= 1'b0;
      mcu_reset <= 1'b0;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_we    <= 1'b0;
      dbg_addr  <= 32'h0;
      dbg_din   <= 32'h0;
    end else begin
      mcu_reset <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            cmd_q  <= cmd;
            addr_q <= addr;
            din_q  <= d_in;
            error  <= 1'b0;
            busy   <= 1'b1;
            state  <= StExec;
          end
        end

        StExec: begin
          cnt   <= '0;
          state <= StDone;
          case (cmd_q)
            CmdNop:    d_rd <= 32'h0;
            CmdStatus: d_rd <= {31'b0, mcu_paused};
            CmdReset: begin
              mcu_reset <= 1'b1;
              d_rd      <= 32'h0;
            end
            CmdPause: begin
              mcu_pause <= 1'b1;
              state     <= StPauseWait;
            end
            CmdResume: begin
              mcu_pause <= 1'b0;
              state     <= StResumeWait;
            end
            CmdMemRd, CmdMemWr: begin
              if (!mcu_paused || (addr_q[1:0] != 2'b00)) begin
                d_rd  <= ErrWord;
                error <= 1'b1;
              end else begin
                dbg_addr <= addr_q;
                dbg_din  <= din_q;
                mem_rd   <= (cmd_q == CmdMemRd);
                mem_we   <= (cmd_q == CmdMemWr);
                state    <= StAccess;
              end
            end
            CmdRegRd, CmdRegWr: begin
              if (!mcu_paused) begin
                d_rd  <= ErrWord;
                error <= 1'b1;
              end else begin
                // Register file has 32 entries; upper index bits are don't-care.
                dbg_addr <= {27'b0, addr_q[4:0]};
                dbg_din  <= din_q;
                reg_rd   <= (cmd_q == CmdRegRd);
                reg_we   <= (cmd_q == CmdRegWr);
                state    <= StAccess;
              end
            end
            default: begin
              d_rd  <= ErrWord;
              error <= 1'b1;
            end
          endcase
        end

        StPauseWait: begin
          if (mcu_paused) begin
            d_rd  <= 32'h0;
            state <= StDone;
          end else if (cnt == CntLast) begin
            // mcu_pause stays asserted so a late halt is not lost.
            d_rd  <= ErrWord;
            error <= 1'b1;
            state <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StResumeWait: begin
          if (!mcu_paused) begin
            d_rd  <= 32'h0;
            state <= StDone;
          end else if (cnt == CntLast) begin
            d_rd  <= ErrWord;
            error <= 1'b1;
            state <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StAccess: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mcu_ack) begin
            d_rd   <= (mem_rd || reg_rd) ? mcu_dout : 32'h0;
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            reg_rd <= 1'b0;
            reg_we <= 1'b0;
            state  <= StDone;
          end else if (cnt == CntLast) begin
            d_rd   <= ErrWord;
            error  <= 1'b1;
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            reg_rd <= 1'b0;
            reg_we <= 1'b0;
            state  <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller with a background MCU responder.
module tb_debug_controller;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        in_valid;
  logic        busy;
  logic [31:0] d_rd;
  logic        error;
  logic        mcu_pause;
  logic        mcu_paused;
  logic        mcu_reset;
  logic        mem_rd;
  logic        mem_we;
  logic        reg_rd;
  logic        reg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_din;
  logic [31:0] mcu_dout;
  logic        mcu_ack = 1'b0;

  debug_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .addr       (addr),
    .d_in       (d_in),
    .in_valid   (in_valid),
    .busy       (busy),
    .d_rd       (d_rd),
    .error      (error),
    .mcu_pause  (mcu_pause),
    .mcu_paused (mcu_paused),
    .mcu_reset  (mcu_reset),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .reg_rd     (reg_rd),
    .reg_we     (reg_we),
    .dbg_addr   (dbg_addr),
    .dbg_din    (dbg_din),
    .mcu_dout   (mcu_dout),
    .mcu_ack    (mcu_ack)
  );

  always #5 clk = ~clk;

  // Responder/monitor: cumulative per-line high-cycle counts, ack after ack_delay cycles.
  int          ack_delay = 0;
  int          acnt = 0;
  int          n_mem_rd = 0, n_mem_we = 0, n_reg_rd = 0, n_reg_we = 0;
  int          n_rst = 0, n_overlap = 0;
  logic [31:0] last_addr = 32'h0, last_din = 32'h0;

  always @(negedge clk) begin
    if (mem_rd) n_mem_rd++;
    if (mem_we) n_mem_we++;
    if (reg_rd) n_reg_rd++;
    if (reg_we) n_reg_we++;
    if (mcu_reset) n_rst++;
    if ((int'(mem_rd) + int'(mem_we) + int'(reg_rd) + int'(reg_we)) > 1) n_overlap++;
    if (mem_rd || mem_we || reg_rd || reg_we) begin
      last_addr = dbg_addr;
      last_din  = dbg_din;
      acnt++;
      mcu_ack = (ack_delay != 0) && (acnt == ack_delay);
    end else begin
      acnt    = 0;
      mcu_ack = 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  int b_mem_rd, b_mem_we, b_reg_rd, b_reg_we, b_rst;

  task automatic snap();
    b_mem_rd = n_mem_rd;
    b_mem_we = n_mem_we;
    b_reg_rd = n_reg_rd;
    b_reg_we = n_reg_we;
    b_rst    = n_rst;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd = c; addr = a; d_in = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (busy) check("done_bound", 32'(busy), 32'd0);
  endtask

  task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                     output int lat);
    snap();
    issue(c, a, d);
    wait_done(lat);
  endtask

  int lat;

  initial begin
    reset = 1'b1; cmd = 4'h0; addr = 32'h0; d_in = 32'h0; in_valid = 1'b0;
    mcu_paused = 1'b0; mcu_dout = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {d_rd[29:0], error, mcu_pause}, 32'd0);
    reset = 1'b0;

    // NOP: busy for two cycles, zero result, no MCU activity.
    snap();
    issue(4'h0, 32'h0, 32'h0);
    check("nop_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    check("nop_busy_n2", 32'(busy), 32'd1);
    @(negedge clk);
    check("nop_busy_n3", 32'(busy), 32'd0);
    check("nop_d_rd", d_rd, 32'h0);
    check("nop_error", 32'(error), 32'd0);
    check("nop_mcu", 32'(n_mem_rd - b_mem_rd + n_mem_we - b_mem_we + n_reg_rd - b_reg_rd
                         + n_reg_we - b_reg_we + n_rst - b_rst + int'(mcu_pause)), 32'd0);

    // MEM_RD while running is rejected without a request.
    run(4'h5, 32'h100, 32'h0, lat);
    check("unp_lat", 32'(lat), 32'd2);
    check("unp_error", 32'(error), 32'd1);
    check("unp_d_rd", d_rd, 32'hFFFF_FFFF);
    check("unp_no_rd", 32'(n_mem_rd - b_mem_rd), 32'd0);

    // PAUSE, halt ack arrives three cycles later.
    issue(4'h1, 32'h0, 32'h0);
    @(negedge clk);
    check("pause_req", 32'(mcu_pause), 32'd1);
    check("pause_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    mcu_paused = 1'b1;
    wait_done(lat);
    check("pause_error", 32'(error), 32'd0);
    check("pause_hold", 32'(mcu_pause), 32'd1);

    run(4'h3, 32'h0, 32'h0, lat);
    check("status_p", d_rd, 32'h1);

    // MEM_WR acked on the 5th request cycle; a strobe while busy must be dropped.
    ack_delay = 5;
    snap();
    issue(4'h6, 32'h200, 32'hCAFE_BABE);
    issue(4'h4, 32'h0, 32'h0);
    wait_done(lat);
    check("wr_we_cycles", 32'(n_mem_we - b_mem_we), 32'd5);
    check("wr_din", last_din, 32'hCAFE_BABE);
    check("wr_addr", last_addr, 32'h200);
    check("wr_d_rd", d_rd, 32'h0);
    check("wr_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    check("ignored_busy", 32'(busy), 32'd0);
    check("ignored_rst", 32'(n_rst - b_rst), 32'd0);

    // Misaligned memory read.
    run(4'h5, 32'h202, 32'h0, lat);
    check("mis_error", 32'(error), 32'd1);
    check("mis_d_rd", d_rd, 32'hFFFF_FFFF);
    check("mis_no_rd", 32'(n_mem_rd - b_mem_rd), 32'd0);

    // REG_RD index 0x25 folds to 5.
    ack_delay = 2; mcu_dout = 32'h1234_5678;
    run(4'h7, 32'h25, 32'h0, lat);
    check("rr_addr", last_addr, 32'h5);
    check("rr_d_rd", d_rd, 32'h1234_5678);
    check("rr_cycles", 32'(n_reg_rd - b_reg_rd), 32'd2);
    check("rr_error", 32'(error), 32'd0);

    // Timeout: no ack, then ack on the final cycle wins.
    ack_delay = 0;
    run(4'h5, 32'h300, 32'h0, lat);
    check("to_cycles", 32'(n_mem_rd - b_mem_rd), 32'(TO));
    check("to_error", 32'(error), 32'd1);
    check("to_d_rd", d_rd, 32'hFFFF_FFFF);
    ack_delay = 8; mcu_dout = 32'hA5A5_0001;
    run(4'h5, 32'h300, 32'h0, lat);
    check("late_cycles", 32'(n_mem_rd - b_mem_rd), 32'(TO));
    check("late_error", 32'(error), 32'd0);
    check("late_d_rd", d_rd, 32'hA5A5_0001);

    // REG_WR with immediate ack.
    ack_delay = 1;
    run(4'h8, 32'h3, 32'h55, lat);
    check("rw_cycles", 32'(n_reg_we - b_reg_we), 32'd1);
    check("rw_din", last_din, 32'h55);
    check("rw_d_rd", d_rd, 32'h0);

    // MCU_RESET: single pulse, pause request untouched.
    run(4'h4, 32'h0, 32'h0, lat);
    check("mr_pulse", 32'(n_rst - b_rst), 32'd1);
    check("mr_pause", 32'(mcu_pause), 32'd1);
    check("mr_lat", 32'(lat), 32'd2);

    // Reset mid-access clears everything.
    ack_delay = 0;
    issue(4'h5, 32'h400, 32'h0);
    repeat (2) @(negedge clk);
    check("mid_rd", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", {busy, mem_rd, mcu_pause, error, mem_we, reg_rd, reg_we, mcu_reset},
          32'd0);
    check("mid_rst_data", d_rd | dbg_addr | dbg_din, 32'h0);
    reset = 1'b0;
    run(4'h3, 32'h0, 32'h0, lat);
    check("post_rst_status", d_rd, 32'h1);
    check("post_rst_lat", 32'(lat), 32'd2);

    // Illegal command.
    run(4'hA, 32'h0, 32'h0, lat);
    check("ill_error", 32'(error), 32'd1);
    check("ill_d_rd", d_rd, 32'hFFFF_FFFF);

    // RESUME: halt drops two cycles later.
    issue(4'h1, 32'h0, 32'h0);
    wait_done(lat);
    issue(4'h2, 32'h0, 32'h0);
    @(negedge clk);
    check("res_pause", 32'(mcu_pause), 32'd0);
    @(negedge clk);
    mcu_paused = 1'b0;
    wait_done(lat);
    check("res_error", 32'(error), 32'd0);
    run(4'h3, 32'h0, 32'h0, lat);
    check("status_r", d_rd, 32'h0);

    check("onehot", 32'(n_overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Sits between the UART command front end and the MCU debug port.
- Accepts one decoded command (cmd, addr, d_in) per in_valid pulse.
- Sequences the matching MCU action: pause/resume handshake, MCU reset pulse, memory or register-file read/write.
- Returns a 32-bit result plus an error flag, holding busy high for the whole operation.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for any MCU acknowledge before aborting with error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd  in  4  command code
- addr  in  32  memory address or register index
- d_in  in  32  write data
- in_valid  in  1  one-cycle command strobe
- busy  out  1  command in progress
- d_rd  out  32  result word, valid when busy falls
- error  out  1  last command failed; valid when busy falls
- mcu_pause  out  1  level request to halt MCU
- mcu_paused  in  1  MCU halted acknowledge
- mcu_reset  out  1  one-cycle MCU reset pulse
- mem_rd  out  1  memory read request (level)
- mem_we  out  1  memory write request (level)
- reg_rd  out  1  register read request (level)
- reg_we  out  1  register write request (level)
- dbg_addr  out  32  address/index to MCU
- dbg_din  out  32  write data to MCU
- mcu_dout  in  32  read data from MCU, valid with mcu_ack
- mcu_ack  in  1  access complete

Behaviour:
- On reset (any state, including mid-operation), all outputs go to 0, the state goes to S_IDLE and the timeout counter clears.
- Command codes:
  - 0x0 NOP
  - 0x1 PAUSE
  - 0x2 RESUME
  - 0x3 STATUS
  - 0x4 MCU_RESET
  - 0x5 MEM_RD
  - 0x6 MEM_WR
  - 0x7 REG_RD
  - 0x8 REG_WR
  - 0x9-0xF are illegal.
- Acceptance: in_valid is sampled only in S_IDLE. In other states it is ignored, with no queueing.
  - On accept, cmd/addr/d_in are latched and error clears.
  - busy=1 from the next cycle.
- States:
  - S_IDLE
  - S_EXEC (decode/dispatch, one cycle)
  - S_PAUSE_WAIT
  - S_RESUME_WAIT
  - S_ACCESS
  - S_DONE
- S_EXEC dispatch:
  - NOP: d_rd=0 -> S_DONE.
  - STATUS: d_rd={31'b0, mcu_paused} -> S_DONE.
  - MCU_RESET: mcu_reset=1 for exactly one cycle; d_rd=0 -> S_DONE. mcu_pause is unchanged.
  - PAUSE: mcu_pause<=1 -> S_PAUSE_WAIT. If already paused, the wait still completes on the first cycle mcu_paused=1.
  - RESUME: mcu_pause<=0 -> S_RESUME_WAIT, completes on first cycle mcu_paused=0.
  - MEM_RD/MEM_WR/REG_RD/REG_WR: require mcu_paused=1, else error.
    - MEM_* require addr[1:0]==0, else error.
    - REG_* use dbg_addr={27'b0, addr[4:0]}; upper addr bits are ignored.
    - Valid accesses drive dbg_addr/dbg_din and raise exactly one of the request lines -> S_ACCESS.
  - Illegal cmd: error.
  - Any error path: d_rd=32'hFFFF_FFFF, error=1 -> S_DONE. No MCU request is issued.
- S_ACCESS:
  - The request stays high until the first cycle mcu_ack=1. That cycle drops the request, captures d_rd=mcu_dout for reads (0 for writes), and goes to S_DONE.
- Timeout (S_PAUSE_WAIT, S_RESUME_WAIT, S_ACCESS):
  - The counter starts at 0 on entry and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES: request dropped, d_rd=32'hFFFF_FFFF, error=1 -> S_DONE.
  - On a PAUSE timeout, mcu_pause is left asserted.
  - If the ack/paused condition and the timeout coincide in the same cycle, the ack wins (success).
- S_DONE: busy<=0 -> S_IDLE.
  - d_rd and error are held stable until the next accepted command.
- Latency (in_valid at cycle N):
  - busy=1 at N+1.
  - NOP/STATUS/MCU_RESET/error: busy=0 with result at N+3.
  - Accesses: busy=0 two cycles after the mcu_ack cycle.
- At most one of mem_rd/mem_we/reg_rd/reg_we is high in any cycle.

Test Plan:
- Reset, then NOP -> busy high for cycles N+1..N+2, d_rd=0, error=0; all MCU outputs stay 0.
- MEM_RD addr=0x100 while unpaused -> no mem_rd, error=1, d_rd=0xFFFFFFFF. Then PAUSE with mcu_paused raised 3 cycles later -> error=0. STATUS -> d_rd=1.
- Paused; MEM_WR addr=0x200 d_in=0xCAFEBABE, ack after 5 cycles -> mem_we high exactly 5 cycles, dbg_din=0xCAFEBABE, d_rd=0. MEM_RD addr=0x202 -> error, no mem_rd.
- Paused; REG_RD addr=0x25 with mcu_dout=0x12345678 on ack -> dbg_addr=5, d_rd=0x12345678.
- Paused; MEM_RD with no ack, TIMEOUT_CYCLES=8 -> mem_rd drops after 8 cycles, error=1. Repeat with ack on the 8th cycle -> success.
- in_valid pulses while busy -> ignored. Assert reset during S_ACCESS -> all outputs 0 next cycle, the next command is accepted normally. Cmd 0xA -> error.
